// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and writeback-stage types.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_R,
        SRC_I,
        SRC_U,
        SRC_LINK,
        SRC_LOAD
    } wb_src_e;

    function automatic wb_src_e decode_src(input logic [6:0] opcode);
        case (opcode)
            OPC_OP:              return SRC_R;
            OPC_OP_IMM:          return SRC_I;
            OPC_LUI, OPC_AUIPC:  return SRC_U;
            OPC_JAL, OPC_JALR:   return SRC_LINK;
            OPC_LOAD:            return SRC_LOAD;
            default:             return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write RV32I register file; x0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_2r1w (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [1:31];
    logic        wr_live;

    assign wr_live = we && (waddr != 5'd0);

    // NOTE: the array is reset because the core relies on all registers reading 0
    // after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && raddr1 == waddr) rdata1 = wdata;
        if (wr_live && raddr2 == waddr) rdata2 = wdata;
`else
`endif
    end

endmodule

// File: rtl/reg_writeback.sv
// Register file plus writeback source select and load-return handshake FSM.
// Optional REGFILE_BYPASS_EN forwards write data to same-cycle reads.
module reg_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] idata,
    input  logic [31:0] regdata_R,
    input  logic [31:0] regdata_I,
    input  logic [31:0] regdata_U,
    input  logic [31:0] pc_plus4,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rv1,
    output logic [31:0] rv2,
    output logic        stall,
    output logic        load_err
);

    localparam logic [7:0] LAST_WAIT = 8'(LOAD_TIMEOUT - 1);

    wb_state_e   state;
    logic [4:0]  ld_rd;
    logic [7:0]  cnt;
    wb_src_e     src;
    logic        timeout;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        unused_bits;

    assign unused_bits = ^{idata[31:25], idata[14:12]};
    assign src         = decode_src(idata[6:0]);
    assign timeout     = (state == WAIT_LOAD) && !mem_rvalid && (cnt == LAST_WAIT);
    assign stall       = ((state == IDLE) && (src == SRC_LOAD)) ||
                         ((state == WAIT_LOAD) && !mem_rvalid && !timeout);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = idata[11:7];
        wdata = '0;
        if (state == IDLE) begin
            case (src)
                SRC_R:    begin we = 1'b1; wdata = regdata_R; end
                SRC_I:    begin we = 1'b1; wdata = regdata_I; end
                SRC_U:    begin we = 1'b1; wdata = regdata_U; end
                SRC_LINK: begin we = 1'b1; wdata = pc_plus4;  end
                default:  we = 1'b0;
            endcase
        end else if (mem_rvalid) begin
            we    = 1'b1;
            waddr = ld_rd;
            wdata = mem_rdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ld_rd    <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (src == SRC_LOAD) begin
                        ld_rd <= idata[11:7];
                        cnt   <= '0;
                        state <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        state    <= IDLE;
                        load_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    regfile_2r1w u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (idata[19:15]),
        .raddr2 (idata[24:20]),
        .rdata1 (rv1),
        .rdata2 (rv2)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_reg_writeback;

    localparam int LT = 16;

    localparam logic [6:0] M_OP     = 7'b0110011;
    localparam logic [6:0] M_OP_IMM = 7'b0010011;
    localparam logic [6:0] M_LOAD   = 7'b0000011;
    localparam logic [6:0] M_LUI    = 7'b0110111;
    localparam logic [6:0] M_AUIPC  = 7'b0010111;
    localparam logic [6:0] M_JAL    = 7'b1101111;
    localparam logic [6:0] M_JALR   = 7'b1100111;
    localparam logic [6:0] M_STORE  = 7'b0100011;
    localparam logic [6:0] M_BRANCH = 7'b1100011;
    localparam logic [6:0] M_SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] idata = '0;
    logic [31:0] regdata_R = '0, regdata_I = '0, regdata_U = '0, pc_plus4 = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] rv1, rv2;
    logic        stall, load_err;

    reg_writeback #(.LOAD_TIMEOUT(LT)) dut (
        .clk(clk), .rst_n(rst_n), .idata(idata),
        .regdata_R(regdata_R), .regdata_I(regdata_I), .regdata_U(regdata_U),
        .pc_plus4(pc_plus4), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rv1(rv1), .rv2(rv2), .stall(stall), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic        stall;
        logic        load_err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: architectural registers plus "load in flight" bookkeeping.
    logic [31:0] m_regs [32];
    bit          m_pending;
    logic [4:0]  m_ld_rd;
    int          m_waited;
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit we, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`else
        if (we && wa == a && wa == 5'd0) return '0;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, opc};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pending = 0;
        m_ld_rd   = '0;
        m_waited  = 0;
        m_err     = 0;
    endtask

    // One core cycle: apply inputs, predict outputs, advance the model, wait one clock.
    task automatic do_cycle(input logic [31:0] ins, input logic [31:0] r, input logic [31:0] i_res,
                            input logic [31:0] u, input logic [31:0] link, input logic rv,
                            input logic [31:0] rdat, input logic rst);
        exp_t        e;
        bit          we, next_err;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [6:0]  opc;
        idata = ins; regdata_R = r; regdata_I = i_res; regdata_U = u; pc_plus4 = link;
        mem_rvalid = rv; mem_rdata = rdat; rst_n = rst;
        opc = ins[6:0];
        e.cyc = cyc;
        e.stall = 1'b0;
        we = 0; wa = '0; wd = '0; next_err = 0;
        if (!rst) begin
            m_reset();
            e.stall = (opc == M_LOAD);
            e.load_err = 1'b0;
            e.rv1 = '0;
            e.rv2 = '0;
        end else begin
            if (!m_pending) begin
                wa = ins[11:7];
                case (opc)
                    M_OP:              begin we = 1; wd = r;     end
                    M_OP_IMM:          begin we = 1; wd = i_res; end
                    M_LUI, M_AUIPC:    begin we = 1; wd = u;     end
                    M_JAL, M_JALR:     begin we = 1; wd = link;  end
                    M_LOAD:            e.stall = 1'b1;
                    default:           we = 0;
                endcase
            end else begin
                if (rv) begin
                    we = 1; wa = m_ld_rd; wd = rdat;
                end else if (m_waited + 1 == LT) begin
                    next_err = 1;
                end
                e.stall = !rv && (m_waited + 1 < LT);
            end
            e.load_err = m_err;
            e.rv1 = m_read(ins[19:15], we, wa, wd);
            e.rv2 = m_read(ins[24:20], we, wa, wd);
            if (we && wa != 5'd0) m_regs[wa] = wd;
            m_err = next_err;
            if (!m_pending && opc == M_LOAD) begin
                m_pending = 1; m_ld_rd = ins[11:7]; m_waited = 0;
            end else if (m_pending) begin
                m_waited++;
                if (rv || m_waited == LT) m_pending = 0;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic nop(input logic [4:0] rs1, input logic [4:0] rs2, input logic rv, input logic [31:0] rdat);
        do_cycle(mk(M_STORE, 5'd0, rs1, rs2), $urandom, $urandom, $urandom, $urandom, rv, rdat, 1'b1);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("rv1",      rv1,             e.rv1,             e.cyc);
                check("rv2",      rv2,             e.rv2,             e.cyc);
                check("stall",    32'(stall),      32'(e.stall),      e.cyc);
                check("load_err", 32'(load_err),   32'(e.load_err),   e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  opcs [10];
        logic [31:0] ins;
        m_reset();
        opcs = '{M_OP, M_OP_IMM, M_LOAD, M_LUI, M_AUIPC, M_JAL, M_JALR, M_STORE, M_BRANCH, M_SYSTEM};
        @(posedge clk);
        #1;
        // Reset state, including a LOAD opcode showing stall while in reset.
        do_cycle(mk(M_STORE, 5'd0, 5'd5, 5'd7), '0, '0, '0, '0, 1'b0, '0, 1'b0);
        do_cycle(mk(M_LOAD, 5'd4, 5'd1, 5'd2), '0, '0, '0, '0, 1'b1, 32'h1, 1'b0);
        // OP rd=5, then read it back.
        do_cycle(mk(M_OP, 5'd5, 5'd0, 5'd0), 32'h0000_00FF, '0, '0, '0, 1'b0, '0, 1'b1);
        nop(5'd5, 5'd0, 1'b0, '0);
        // OP-IMM to x0 is dropped; mem_rvalid in IDLE is ignored.
        do_cycle(mk(M_OP_IMM, 5'd0, 5'd0, 5'd0), '0, 32'hDEAD_BEEF, '0, '0, 1'b1, 32'h1111, 1'b1);
        nop(5'd0, 5'd5, 1'b1, 32'h2222);
        // LOAD rd=7, data on the third wait cycle.
        for (int k = 0; k < 3; k++)
            do_cycle(mk(M_LOAD, 5'd7, 5'd7, 5'd5), $urandom, $urandom, $urandom, $urandom, 1'b0, '0, 1'b1);
        do_cycle(mk(M_LOAD, 5'd7, 5'd7, 5'd5), $urandom, $urandom, $urandom, $urandom, 1'b1, 32'h1234_5678, 1'b1);
        nop(5'd7, 5'd5, 1'b0, '0);
        // Earliest acceptance: data in N+1.
        do_cycle(mk(M_LOAD, 5'd8, 5'd0, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b0, '0, 1'b1);
        do_cycle(mk(M_LOAD, 5'd8, 5'd8, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b1, 32'h0BAD_F00D, 1'b1);
        nop(5'd8, 5'd7, 1'b0, '0);
        // LOAD rd=9 that times out; x9 keeps its earlier value.
        do_cycle(mk(M_OP, 5'd9, 5'd0, 5'd0), 32'h0000_0055, '0, '0, '0, 1'b0, '0, 1'b1);
        for (int k = 0; k <= LT; k++)
            do_cycle(mk(M_LOAD, 5'd9, 5'd9, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b0, '0, 1'b1);
        nop(5'd9, 5'd0, 1'b0, '0);
        nop(5'd9, 5'd0, 1'b0, '0);
        // Data arriving on the final wait cycle beats the timeout.
        for (int k = 0; k < LT; k++)
            do_cycle(mk(M_LOAD, 5'd10, 5'd10, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b0, '0, 1'b1);
        do_cycle(mk(M_LOAD, 5'd10, 5'd10, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b1, 32'hFACE_0010, 1'b1);
        nop(5'd10, 5'd0, 1'b0, '0);
        // Same-cycle read of the register being written.
        do_cycle(mk(M_OP, 5'd3, 5'd0, 5'd3), 32'hA5A5_A5A5, '0, '0, '0, 1'b0, '0, 1'b1);
        nop(5'd0, 5'd3, 1'b0, '0);
        // Reset in N+2 of a pending load, then stray data after release.
        do_cycle(mk(M_LOAD, 5'd11, 5'd11, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b0, '0, 1'b1);
        do_cycle(mk(M_LOAD, 5'd11, 5'd11, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b0, '0, 1'b1);
        do_cycle(mk(M_LOAD, 5'd11, 5'd11, 5'd0), $urandom, $urandom, $urandom, $urandom, 1'b1, 32'hCAFE_CAFE, 1'b0);
        nop(5'd11, 5'd3, 1'b1, 32'hCAFE_CAFE);
        nop(5'd11, 5'd0, 1'b0, '0);
        // Random traffic; the instruction is held while the model says a load is in flight.
        ins = mk(M_STORE, 5'd0, 5'd0, 5'd0);
        for (int n = 0; n < 600; n++) begin
            if (!m_pending) begin
                ins = $urandom;
                if ($urandom_range(0, 3) == 0) ins[6:0] = M_LOAD;
                else ins[6:0] = opcs[$urandom_range(0, 9)];
            end else begin
                ins[24:15] = 10'($urandom);
            end
            do_cycle(ins, $urandom, $urandom, $urandom, $urandom,
                     1'($urandom_range(0, 3) == 0), $urandom, 1'b1);
        end
        nop(5'd1, 5'd2, 1'b0, '0);
        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
